// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

  localparam int MIPS_ADDR_W  = 32;
  localparam int MIPS_INSTR_W = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    REQ
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} pairs; flush wins over push, head is zeroed when empty.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int ADDR_W  = MIPS_ADDR_W,
  parameter int INSTR_W = MIPS_INSTR_W,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_pc,
  output logic [INSTR_W-1:0]       head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign head_pc    = empty ? '0 : pc_mem[rd_ptr];
  assign head_instr = empty ? INSTR_W'(NOP_INSTR) : instr_mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch: owns the PC, issues one outstanding imem read at a time,
// buffers responses in a prefetch FIFO and handles datapath redirects.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = MIPS_ADDR_W,
  parameter int                INSTR_W  = MIPS_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic              discard, discard_nxt;
  logic              ack_fire, push, pop;
  logic [CW-1:0]     count, count_after;
  logic              full, empty;

  assign imem_req    = (state == REQ);
  assign imem_addr   = req_addr;
  assign ack_fire    = imem_req && imem_ack;
  assign push        = ack_fire && !discard && !br_taken;
  assign pop         = if_valid && if_ready;
  assign if_valid    = !empty;
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    discard_nxt  = discard;

    if (br_taken)  fetch_pc_nxt = br_target & ~ADDR_W'(3);
    else if (push) fetch_pc_nxt = fetch_pc + ADDR_W'(PC_INC);

    case (state)
      IDLE: begin
        // Without a request in flight, room after this cycle is just count minus any pop.
        req_addr_nxt = fetch_pc_nxt;
        if (br_taken || !full || pop) state_nxt = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          discard_nxt  = 1'b0;
          req_addr_nxt = fetch_pc_nxt;
          if (!br_taken && count_after == CW'(DEPTH)) state_nxt = IDLE;
        end else if (br_taken) begin
          // Address stays on the bus until the stale response returns.
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
      discard  <= discard_nxt;
    end
  end

  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (br_taken),
    .push       (push),
    .push_pc    (req_addr),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus randomized traffic checked
// against an in-order instruction stream model.
module tb_mips_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;

  logic        w_rst_n = 1'b0;
  logic        w_req, w_ack = 1'b0;
  logic [31:0] w_addr, w_rdata = '0;
  logic        w_valid, w_ready = 1'b1;
  logic [31:0] w_instr, w_pc;
  logic        w_br = 1'b0;
  logic [31:0] w_tgt = '0;

  int n_checks = 0;
  int n_errors = 0;

  int  lat_cfg = 0;
  int  cur_lat = 0;
  int  busy = 0;
  bit  prev_req = 0, prev_ack = 0, force_stale = 0;

  logic [31:0] exp_pc = '0;
  int          acc_cnt = 0;
  int          ack_cnt = 0;
  bit          mon_prev_wait = 0;
  logic [31:0] mon_prev_addr = '0;

  always #5 clk = ~clk;

  mips_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .br_taken(br_taken), .br_target(br_target)
  );

  mips_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_ready(w_ready),
    .br_taken(w_br), .br_target(w_tgt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: responds after a per-request latency, data derived from address.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) busy = 0;
      else if (prev_req && prev_ack) begin
        busy = 0;
        cur_lat = $urandom_range(0, 3);
      end else if (prev_req) busy++;
      if (force_stale) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req) begin
        imem_ack = (busy >= ((lat_cfg >= 0) ? lat_cfg : cur_lat));
        imem_rdata = imem_addr ^ KEY;
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      w_ack = w_req;
      w_rdata = w_addr ^ KEY;
    end
  end

  // Stream model: accepted instructions must follow PC order, restarting at each redirect.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_pc = 32'h0;
        mon_prev_wait = 0;
      end else begin
        if (mon_prev_wait) begin
          chk("req_hold", {31'b0, imem_req}, 32'd1);
          chk("addr_hold", imem_addr, mon_prev_addr);
        end
        if (imem_req) begin
          chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
          if (imem_ack) ack_cnt++;
        end
        mon_prev_wait = imem_req && !imem_ack;
        mon_prev_addr = imem_addr;
        if (if_valid && if_ready) begin
          chk("sb_pc", if_pc, exp_pc);
          chk("sb_instr", if_instr, exp_pc ^ KEY);
          exp_pc = exp_pc + 32'd4;
          acc_cnt++;
        end
        if (br_taken) exp_pc = br_target & ~32'd3;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    br_taken = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int a0;
    bit got;

    // Reset state, first-fetch latency and zero-wait throughput.
    lat_cfg = 0;
    if_ready = 1'b1;
    do_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t1_req_rise", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_not_valid", {31'b0, if_valid}, 32'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("t1_valid", {31'b0, if_valid}, 32'd1);
      chk("t1_pc", if_pc, 32'(4 * (k - 2)));
      chk("t1_instr", if_instr, 32'(4 * (k - 2)) ^ KEY);
    end

    // Redirect coinciding with an ack and a pop.
    br_taken = 1'b1;
    br_target = 32'h0000_0202;
    tick();
    br_taken = 1'b0;
    chk("t4_empty", {31'b0, if_valid}, 32'd0);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    tick();
    chk("t4_valid", {31'b0, if_valid}, 32'd1);
    chk("t4_pc", if_pc, 32'h200);
    chk("t4_instr", if_instr, 32'h200 ^ KEY);

    // Back-pressure fills the FIFO, then drains without gaps.
    if_ready = 1'b0;
    do_reset();
    a0 = ack_cnt;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t2_acks", 32'(ack_cnt - a0), 32'd4);
    chk("t2_req_low", {31'b0, imem_req}, 32'd0);
    chk("t2_head", if_pc, 32'h0);
    if_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_drain_pc", if_pc, 32'(4 * k));
    end

    // Slow memory with a redirect while the request is outstanding.
    lat_cfg = 3;
    do_reset();
    rst_n = 1'b1;
    tick();
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    tick();
    br_taken = 1'b1;
    br_target = 32'h0000_0103;
    tick();
    br_taken = 1'b0;
    chk("t3_addr_held", imem_addr, 32'h0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (imem_ack) got = 1;
    end
    chk("t3_ack_seen", {31'b0, got}, 32'd1);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_new_req", {31'b0, imem_req}, 32'd1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (if_valid) got = 1;
      else tick();
    end
    chk("t3_valid_seen", {31'b0, got}, 32'd1);
    chk("t3_first_pc", if_pc, 32'h100);

    // Reset while a request is in flight and two entries are buffered.
    lat_cfg = 2;
    if_ready = 1'b0;
    do_reset();
    a0 = ack_cnt;
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (ack_cnt - a0 >= 2) got = 1;
    end
    chk("t6_two_acks", {31'b0, got}, 32'd1);
    chk("t6_busy", {31'b0, imem_req}, 32'd1);
    chk("t6_head", if_pc, 32'h0);
    rst_n = 1'b0;
    force_stale = 1'b1;
    tick();
    chk("t6_valid_drop", {31'b0, if_valid}, 32'd0);
    chk("t6_req_drop", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;
    if_ready = 1'b1;
    tick();
    force_stale = 1'b0;
    chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (if_valid) got = 1;
      else tick();
    end
    chk("t6_valid_seen", {31'b0, got}, 32'd1);
    chk("t6_first_pc", if_pc, 32'h0);
    chk("t6_first_instr", if_instr, KEY);

    // PC wrap from a high reset vector.
    chk("t5_rst_addr", w_addr, 32'hFFFF_FFF8);
    w_rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_valid", {31'b0, w_valid}, 32'd1);
      chk("t5_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("t5_instr", w_instr, (32'hFFFF_FFF8 + 32'(4 * k)) ^ KEY);
    end

    // Randomized traffic: variable latency, back-pressure and redirects.
    lat_cfg = -1;
    do_reset();
    a0 = acc_cnt;
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      br_taken = ($urandom_range(0, 19) == 0);
      br_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
      tick();
    end
    br_taken = 1'b0;
    if_ready = 1'b1;
    tick();
    chk("rand_progress", {31'b0, (acc_cnt - a0) > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction fetch stage directly upstream of the MIPS datapath.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake that allows variable latency.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to the datapath on a valid/ready interface.
- Handles branch/jump redirects from the datapath by flushing the FIFO and discarding any in-flight response.

Parameters:
- ADDR_W, 32, fetch address / PC width.
- INSTR_W, 32, instruction word width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC loaded at reset (word aligned).

Ports:
- clk  in  1  single system clock; all state updates on posedge clk.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word address of the request; bits [1:0] always 0.
- imem_ack  in  1  memory response valid; sampled only while imem_req=1.
- imem_rdata  in  INSTR_W  instruction data, valid when imem_ack=1.
- if_valid  out  1  FIFO head holds a valid instruction.
- if_instr  out  INSTR_W  instruction at FIFO head.
- if_pc  out  ADDR_W  PC of if_instr.
- if_ready  in  1  datapath accepts the head this cycle.
- br_taken  in  1  redirect request from the datapath.
- br_target  in  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; FSM=IDLE.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
  - Reset mid-transaction drops any in-flight request; a late imem_ack after reset is ignored because imem_req=0.
- FSM states:
  - IDLE: no request outstanding. Moves to REQ when count+pending_push < DEPTH. Registered: imem_req rises the cycle after the decision, with imem_addr=fetch_pc.
  - REQ: imem_req=1. imem_addr is held stable until ack.
    - On ack with discard=0: push {fetch_pc, imem_rdata} and set fetch_pc += 4.
    - After ack: stay in REQ with the new address if the FIFO still has room after this cycle's push/pop; otherwise go to IDLE.
- Memory handshake:
  - Zero-wait memory is allowed: ack may arrive in the first cycle req is high.
  - One request outstanding at most.
  - Sustained throughput is 1 instruction/cycle with zero-wait memory and if_ready=1.
- Latency: with zero-wait memory, the first instruction is pushed at posedge P+1, where P is the posedge at which imem_req first rises. if_valid=1 from P+1 onward, i.e. after the second posedge following reset release. The FIFO is not fall-through.
- Output (datapath) handshake:
  - Pop occurs when if_valid & if_ready.
  - if_instr and if_pc are the FIFO head, registered.
  - if_valid falls only on empty or flush.
- Redirect (br_taken=1 at posedge):
  - The FIFO is flushed; count becomes 0 next cycle. A simultaneous pop is still counted as accepted.
  - fetch_pc = {br_target[ADDR_W-1:2], 2'b00}.
  - If a request is outstanding without ack this cycle: set discard=1. imem_req stays high with its old address until ack; that ack's data is dropped, discard clears, and the next request uses the new fetch_pc.
  - Redirect in the same cycle as an ack: the data is dropped, with no push and no +4 increment.
  - Back-to-back redirects: the last one wins.
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO is legal, and count is unchanged.
  - No push is ever issued to a full FIFO, by construction of the issue rule (count plus outstanding request must be < DEPTH).
  - Pop on empty cannot occur because if_valid=0.
- Arithmetic: PC increment is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_W and INSTR_W defaults.
  - PC_INC = 4.
  - NOP_INSTR = 32'h0000_0000.
  - Fetch FSM state enum {IDLE, REQ}.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO of {pc, instr}. It provides push, pop and a flush input (flush has priority over push), and exposes count, full and empty. The top level contains the FSM, PC logic and discard flag.

Test Plan:
- Zero-wait memory returning addr-based data (rdata=addr^32'hA5A5_0000), if_ready=1 → if_pc sequence 0,4,8,C... one per cycle, starting at the second posedge after reset release; each if_instr matches its if_pc.
- if_ready=0 for 10 cycles → exactly 4 entries buffered (PC 0..C); imem_req low; after if_ready=1, drain in order 0,4,8,C, then fetch resumes at 0x10 with no gaps or duplicates.
- Memory with 3-cycle ack latency, br_taken with br_target=0x103 asserted in the second wait cycle → the pending response is discarded; the next imem_addr=0x100, and the first post-redirect if_pc=0x100.
- br_taken in the same cycle as an ack and a pop → the popped instruction is accepted, the acked data does not appear, and the FIFO is empty next cycle with fetch restarting at br_target.
- RESET_PC=32'hFFFF_FFF8 → if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n=0 asserted mid-request with the FIFO holding 2 entries → the next cycle shows if_valid=0 and imem_req=0; a stale ack is ignored, and fetch restarts at RESET_PC.
